// File: rtl/mste_cpu_speed_ctrl.sv
// Mega STE CPU speed/cache control: CPU-visible register bank plus a sequencer
// that applies speed/cache changes only at bus-idle points, flushing the cache first when needed.
module mste_cpu_speed_ctrl #(
    parameter int ADDR_W     = 2,
    parameter int SETTLE_W   = 8,
    parameter int SETTLE_RST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    input  logic              sel,
    input  logic              ds,
    input  logic              rw,
    output logic [7:0]        dout,
    input  logic              bus_idle,
    input  logic              flush_ack,
    output logic              enable_16mhz,
    output logic              enable_cache,
    output logic              cache_flush,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_FLUSH,
        ST_SWITCH,
        ST_SETTLE
    } state_t;

    state_t              state;
    logic [7:0]          cfg;
    logic [7:0]          scratch;
    logic [SETTLE_W-1:0] settle_reg;
    logic [SETTLE_W-1:0] cnt;
    logic [1:0]          tgt;
    logic [7:0]          settle_rd;
    logic [7:0]          stat;
    logic                wr_en;
    logic                rd_en;
    logic                cfg_differs;
    logic                need_flush;

    assign wr_en = sel & ~ds & ~rw;
    assign rd_en = sel & ~ds & rw;

    assign cfg_differs = (cfg[1:0] != {enable_cache, enable_16mhz});
    // Flush before dropping the cache, or before a speed change while the cache stays live.
    assign need_flush  = enable_cache & (~cfg[1] | (cfg[0] != enable_16mhz));

    assign stat = {busy, 4'b0000, cache_flush, enable_cache, enable_16mhz};

    generate
        if (SETTLE_W >= 8) begin : g_settle_wide
            assign settle_rd = settle_reg[7:0];
        end else begin : g_settle_narrow
            assign settle_rd = {{(8 - SETTLE_W){1'b0}}, settle_reg};
        end
    endgenerate

    // Level-sensitive writes: the register simply follows din while the strobe is held.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cfg        <= 8'h00;
            scratch    <= 8'h00;
            settle_reg <= SETTLE_W'(SETTLE_RST);
        end else if (wr_en) begin
            case (addr)
                ADDR_W'(0): cfg        <= din;
                ADDR_W'(2): settle_reg <= SETTLE_W'(din);
                ADDR_W'(3): scratch    <= din;
                default:    ;
            endcase
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        dout = 8'h00;
        if (rd_en) begin
            case (addr)
                ADDR_W'(0): dout = cfg;
                ADDR_W'(1): dout = stat;
                ADDR_W'(2): dout = settle_rd;
                ADDR_W'(3): dout = scratch;
                default:    dout = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            enable_16mhz <= 1'b0;
            enable_cache <= 1'b0;
            cache_flush  <= 1'b0;
            busy         <= 1'b0;
            tgt          <= 2'b00;
            cnt          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_differs) begin
                        state <= ST_WAIT_IDLE;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    // A request withdrawn before the bus frees up is dropped without switching.
                    if (!cfg_differs) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (bus_idle) begin
                        tgt <= cfg[1:0];
                        if (need_flush) begin
                            state       <= ST_FLUSH;
                            cache_flush <= 1'b1;
                        end else begin
                            state <= ST_SWITCH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack) begin
                        state       <= ST_SWITCH;
                        cache_flush <= 1'b0;
                    end
                end
                ST_SWITCH: begin
                    {enable_cache, enable_16mhz} <= tgt;
                    cnt   <= settle_reg;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - SETTLE_W'(1);
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    cache_flush <= 1'b0;
                end
            endcase
        end
    end

endmodule
